// File: rtl/regfile_pkg.sv
// Shared constants and types for the pipelined register file and its scoreboard.
package regfile_pkg;
  localparam int ZERO_REG          = 0;
  localparam int DEFAULT_DEBUG_REG = 10;
  localparam int MAX_NUM_READ      = 4;

  // Index of a read port; wide enough for the largest supported port count.
  typedef logic [$clog2(MAX_NUM_READ)-1:0] rd_port_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register, a registered population count
// and per-read-port busy lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_READ      = 2,
  parameter int BYPASS        = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              claim,
  input  logic [ADDRESS_WIDTH-1:0]          claim_addr,
  input  logic                              we1,
  input  logic [ADDRESS_WIDTH-1:0]          wa1,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_READ-1:0]               rd_busy,
  output logic [ADDRESS_WIDTH:0]            pending_cnt
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO_REG);

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;
  logic             do_set;
  logic             do_clr;
  logic             set_new;
  logic             clr_eff;

  always_comb begin
    do_set   = claim && (claim_addr != ZERO_IDX);
    do_clr   = we1 && (wa1 != ZERO_IDX);
    set_mask = '0;
    clr_mask = '0;
    if (do_set) set_mask[claim_addr] = 1'b1;
    if (do_clr) clr_mask[wa1] = 1'b1;
    // Count tracks only real transitions; a same-address claim+release keeps the bit set.
    set_new  = do_set && !pending[claim_addr];
    clr_eff  = do_clr && pending[wa1] && !(do_set && (claim_addr == wa1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= (pending & ~clr_mask) | set_mask;
      pending_cnt <= pending_cnt + (ADDRESS_WIDTH+1)'(set_new) - (ADDRESS_WIDTH+1)'(clr_eff);
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
    logic [ADDRESS_WIDTH-1:0] ra;
    logic                     fwd;
    assign ra  = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign fwd = (BYPASS != 0) && we1 && (wa1 == ra);
    assign rd_busy[i] = (ra != ZERO_IDX) && pending[ra] && !fwd;
  end
endmodule

// File: rtl/regfile_sb.sv
// Register file for the pipelined core: NUM_READ combinational read ports,
// execute (port 0) and load (port 1) writeback, optional bypass, pending-load scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int BYPASS        = 1,
  parameter int DEBUG_REG     = DEFAULT_DEBUG_REG
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_READ-1:0]               rd_busy,
  input  logic                              we0,
  input  logic [ADDRESS_WIDTH-1:0]          wa0,
  input  logic [DATA_WIDTH-1:0]             wd0,
  input  logic                              we1,
  input  logic [ADDRESS_WIDTH-1:0]          wa1,
  input  logic [DATA_WIDTH-1:0]             wd1,
  input  logic                              claim,
  input  logic [ADDRESS_WIDTH-1:0]          claim_addr,
  output logic [ADDRESS_WIDTH:0]            pending_cnt,
  output logic [DATA_WIDTH-1:0]             a0
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO_REG);
  localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX  = ADDRESS_WIDTH'(DEBUG_REG);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic w0;
  logic w1_any;
  logic w1;

  always_comb begin
    w0     = we0 && (wa0 != ZERO_IDX);
    w1_any = we1 && (wa1 != ZERO_IDX);
    // Port 0 wins a same-address collision; port 1 data is dropped.
    w1     = w1_any && !(w0 && (wa0 == wa1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      if (w1) mem[wa1] <= wd1;
      if (w0) mem[wa0] <= wd0;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0]    val;
    assign ra = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    always_comb begin
      val = mem[ra];
      if ((BYPASS != 0) && w0 && (wa0 == ra)) val = wd0;
      else if ((BYPASS != 0) && w1_any && (wa1 == ra)) val = wd1;
      if ((ra == ZERO_IDX) || !rst_n) val = '0;
    end
    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = val;
  end

  assign a0 = rst_n ? mem[DBG_IDX] : '0;

  regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_READ      (NUM_READ),
    .BYPASS        (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .claim       (claim),
    .claim_addr  (claim_addr),
    .we1         (we1),
    .wa1         (wa1),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .pending_cnt (pending_cnt)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb, driving a bypassed and a non-bypassed instance in lockstep.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic        we0, we1, claim;
  logic [4:0]  wa0, wa1, claim_addr;
  logic [31:0] wd0, wd1;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [5:0]  cnt_b, cnt_n;
  logic [31:0] a0_b, a0_n;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .claim(claim), .claim_addr(claim_addr), .pending_cnt(cnt_b), .a0(a0_b));

  regfile_sb #(.BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .claim(claim), .claim_addr(claim_addr), .pending_cnt(cnt_n), .a0(a0_n));

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_regs[32];
  logic        m_pend[32];
  string       names[12] = '{"rd0_byp", "rd1_byp", "busy0_byp", "busy1_byp", "cnt_byp", "a0_byp",
                             "rd0_nob", "rd1_nob", "busy0_nob", "busy1_nob", "cnt_nob", "a0_nob"};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] actual_of(int k);
    case (k)
      0:  return rd_data_b[31:0];
      1:  return rd_data_b[63:32];
      2:  return {31'd0, rd_busy_b[0]};
      3:  return {31'd0, rd_busy_b[1]};
      4:  return {26'd0, cnt_b};
      5:  return a0_b;
      6:  return rd_data_n[31:0];
      7:  return rd_data_n[63:32];
      8:  return {31'd0, rd_busy_n[0]};
      9:  return {31'd0, rd_busy_n[1]};
      10: return {26'd0, cnt_n};
      default: return a0_n;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(int byp, logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (byp != 0 && we0 && wa0 == a) return wd0;
    if (byp != 0 && we1 && wa1 == a) return wd1;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(int byp, logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (byp != 0 && we1 && wa1 == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic [31:0] popcount();
    logic [31:0] s = 0;
    for (int i = 0; i < 32; i++) s += {31'd0, m_pend[i]};
    return s;
  endfunction

  task automatic push(input int kind, input logic [31:0] exp);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(names[e.kind], actual_of(e.kind), e.exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic cyc(input logic e0, input logic [4:0] aw0, input logic [31:0] d0,
                     input logic e1, input logic [4:0] aw1, input logic [31:0] d1,
                     input logic cl, input logic [4:0] ca,
                     input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    we0 = e0; wa0 = aw0; wd0 = d0;
    we1 = e1; wa1 = aw1; wd1 = d1;
    claim = cl; claim_addr = ca;
    rd_addr = {r1, r0};
    #1;
    for (int b = 0; b < 2; b++) begin
      push(b*6 + 0, exp_rd(1 - b, r0));
      push(b*6 + 1, exp_rd(1 - b, r1));
      push(b*6 + 2, {31'd0, exp_busy(1 - b, r0)});
      push(b*6 + 3, {31'd0, exp_busy(1 - b, r1)});
    end
    drain();
    @(posedge clk);
    if (we0 && wa0 != 0) m_regs[wa0] = wd0;
    if (we1 && wa1 != 0 && !(we0 && wa0 == wa1)) m_regs[wa1] = wd1;
    if (we1 && wa1 != 0) m_pend[wa1] = 1'b0;
    if (claim && claim_addr != 0) m_pend[claim_addr] = 1'b1;
    #1;
    for (int b = 0; b < 2; b++) begin
      push(b*6 + 4, popcount());
      push(b*6 + 5, m_regs[10]);
    end
    drain();
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next clock edge.
  task automatic reset_pulse(input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    we0 = 0; we1 = 0; claim = 0;
    rd_addr = {r1, r0};
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 6; k++) push(b*6 + k, 32'd0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    we0 = 0; wa0 = 0; wd0 = 0;
    we1 = 0; wa1 = 0; wd1 = 0;
    claim = 0; claim_addr = 0;
    rd_addr = {5'd10, 5'd5};
    model_clear();
    #1;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 6; k++) push(b*6 + k, 32'd0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset clears stored data
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);
    idle(5, 5);
    reset_pulse(5, 5);
    idle(5, 5);

    // Register 0 is hardwired; debug register on a0
    cyc(1, 0, 32'h00001234, 1, 10, 32'h55AA00FF, 0, 0, 0, 10);
    idle(0, 10);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);

    // Dual write to the same register: port 0 wins
    cyc(1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0, 7, 7);
    idle(7, 7);

    // Load-use hazard and release by port 1
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    idle(0, 3);
    cyc(0, 0, 0, 1, 3, 32'hCAFEF00D, 0, 0, 3, 3);
    idle(3, 3);

    // Same-address claim/release keeps the entry; disjoint claim/release nets zero
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    cyc(0, 0, 0, 1, 9, 32'h99999999, 1, 9, 9, 9);
    idle(9, 9);
    cyc(0, 0, 0, 0, 0, 0, 1, 6, 6, 4);
    cyc(0, 0, 0, 1, 6, 32'h66666666, 1, 4, 6, 4);
    cyc(0, 0, 0, 1, 8, 32'h88888888, 0, 0, 8, 4);

    // Fill every register's pending bit, re-claim, then reset mid-sequence
    for (int i = 1; i < 32; i++) cyc(0, 0, 0, 0, 0, 0, 1, 5'(i), 5'(i), 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 31, 31, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 31, 31, 0);
    reset_pulse(31, 1);
    idle(31, 1);

    // Mixed traffic
    for (int n = 0; n < 80; n++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
          5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
